// File: rtl/key_filter_bank_pkg.sv
// Shared types and constants for the key debounce bank.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  // 20 ms of stable level at 50 MHz
  localparam int DEFAULT_CNT_MAX = 1_000_000;

  // Key positions as consumed by the LED control stage
  localparam int KEY_ADD = 0;
  localparam int KEY_SUB = 1;
  localparam int KEY_SHL = 2;
  localparam int KEY_SHR = 3;

endpackage

// File: rtl/key_filter_bank_if.sv
// Key bundle: raw active-low pads in, debounced pulses and levels out.
interface key_filter_bank_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in_n;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_state;

  modport master (
    output key_in_n,
    input  key_press,
    input  key_release,
    input  key_state
  );

  modport slave (
    input  key_in_n,
    output key_press,
    output key_release,
    output key_state
  );
endinterface

// File: rtl/key_filter_bank_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter and
// press/release FSM with registered outputs.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in_n,
  output logic key_press,
  output logic key_release,
  output logic key_state
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [1:0]    sync_q;
  logic          key_s;
  key_fsm_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          level_q, level_d;

  assign key_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer idles at the released pad level
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_in_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_state   = level_q;

endmodule

// File: rtl/key_filter_bank.sv
// Bank of independent key debounce channels sharing one clock.
module key_filter_bank
  import key_filter_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int CNT_MAX  = DEFAULT_CNT_MAX
) (
  input  logic            clk,
  input  logic            reset,
  key_filter_bank_if.slave bus
);

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      key_filter_ch #(
        .CNT_MAX(CNT_MAX)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .key_in_n   (bus.key_in_n[gi]),
        .key_press  (bus.key_press[gi]),
        .key_release(bus.key_release[gi]),
        .key_state  (bus.key_state[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_filter_bank.sv
// Directed bench for key_filter_bank with a short filter window (CNT_MAX=8).
module tb_key_filter_bank;
  import key_filter_pkg::*;

  localparam int NK = 4;
  localparam int CM = 8;
  localparam int LAT = CM + 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Observation window bookkeeping, edge numbers relative to clear_obs
  int edge_no;
  int press_cnt [NK];
  int rel_cnt   [NK];
  int press_edge[NK];
  int rel_edge  [NK];
  int state_hi  [NK];
  int state_fall[NK];
  int both_hi;

  key_filter_bank_if #(.NUM_KEYS(NK)) kif ();

  key_filter_bank #(
    .NUM_KEYS(NK),
    .CNT_MAX (CM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    edge_no = 0;
    both_hi = 0;
    for (int k = 0; k < NK; k++) begin
      press_cnt[k]  = 0;
      rel_cnt[k]    = 0;
      press_edge[k] = -1;
      rel_edge[k]   = -1;
      state_hi[k]   = 0;
      state_fall[k] = -1;
    end
  endtask

  task automatic observe(input int n);
    for (int e = 0; e < n; e++) begin
      @(posedge clk);
      #1;
      edge_no++;
      for (int k = 0; k < NK; k++) begin
        if (kif.key_press[k]) begin
          press_cnt[k]++;
          if (press_edge[k] < 0) press_edge[k] = edge_no;
        end
        if (kif.key_release[k]) begin
          rel_cnt[k]++;
          if (rel_edge[k] < 0) rel_edge[k] = edge_no;
        end
        if (kif.key_press[k] && kif.key_release[k]) both_hi++;
        if (kif.key_state[k]) state_hi[k]++;
        else if (state_fall[k] < 0) state_fall[k] = edge_no;
      end
    end
  endtask

  task automatic drive(input logic [NK-1:0] pins);
    @(negedge clk);
    kif.key_in_n = pins;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kif.key_in_n = 4'b0000;
    clear_obs();
    observe(4);
    n_checks++;
    if (kif.key_state !== 4'b0000 || kif.key_press !== 4'b0000 || kif.key_release !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%b press=%b release=%b, required all 0",
               kif.key_state, kif.key_press, kif.key_release);
    end
    n_checks++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] !== 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: presses seen during reset, required 0");
    end
    drive(4'b1111);
    observe(3);
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    observe(LAT + 4);
    n_checks++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] !== 0 || kif.key_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: state=%b after reset with pins released, required 0000", kif.key_state);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    clear_obs();
    drive(4'b1110);
    observe(20);
    n_checks++;
    if (press_edge[KEY_ADD] !== LAT || press_cnt[KEY_ADD] !== 1) begin
      n_fail++;
      $display("FAIL clean_press: edge=%0d count=%0d, required edge=%0d count=1",
               press_edge[KEY_ADD], press_cnt[KEY_ADD], LAT);
    end
    n_checks++;
    if (kif.key_state !== 4'b0001) begin
      n_fail++;
      $display("FAIL clean_state: key_state=%b, required 0001", kif.key_state);
    end
    n_checks++;
    if (press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[0] !== 0) begin
      n_fail++;
      $display("FAIL clean_others: stray pulses on other keys, required none");
    end
    $display("test_clean_press: press at edge %0d", press_edge[KEY_ADD]);
  endtask

  task automatic test_press_bounce();
    clear_obs();
    drive(4'b1100);
    observe(5);
    drive(4'b1110);
    observe(2);
    n_checks++;
    if (press_cnt[KEY_SUB] !== 0 || kif.key_state[KEY_SUB] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_reject: presses=%0d state=%b, required 0 and 0",
               press_cnt[KEY_SUB], kif.key_state[KEY_SUB]);
    end
    clear_obs();
    drive(4'b1100);
    observe(20);
    n_checks++;
    if (press_edge[KEY_SUB] !== LAT || press_cnt[KEY_SUB] !== 1) begin
      n_fail++;
      $display("FAIL bounce_press: edge=%0d count=%0d, required edge=%0d count=1",
               press_edge[KEY_SUB], press_cnt[KEY_SUB], LAT);
    end
    $display("test_press_bounce: press at edge %0d", press_edge[KEY_SUB]);
  endtask

  task automatic test_release_bounce();
    clear_obs();
    drive(4'b1101);
    observe(3);
    drive(4'b1100);
    observe(1);
    drive(4'b1101);
    n_checks++;
    if (state_fall[KEY_ADD] !== -1 || rel_cnt[KEY_ADD] !== 0) begin
      n_fail++;
      $display("FAIL release_bounce_hold: fall_edge=%0d releases=%0d, required -1 and 0",
               state_fall[KEY_ADD], rel_cnt[KEY_ADD]);
    end
    clear_obs();
    observe(20);
    n_checks++;
    if (rel_edge[KEY_ADD] !== LAT || rel_cnt[KEY_ADD] !== 1) begin
      n_fail++;
      $display("FAIL release_pulse: edge=%0d count=%0d, required edge=%0d count=1",
               rel_edge[KEY_ADD], rel_cnt[KEY_ADD], LAT);
    end
    n_checks++;
    if (state_fall[KEY_ADD] !== LAT || kif.key_state !== 4'b0010) begin
      n_fail++;
      $display("FAIL release_state: fall_edge=%0d state=%b, required %0d and 0010",
               state_fall[KEY_ADD], kif.key_state, LAT);
    end
    clear_obs();
    drive(4'b1111);
    observe(20);
    n_checks++;
    if (rel_edge[KEY_SUB] !== LAT || kif.key_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL release_sub: edge=%0d state=%b, required %0d and 0000",
               rel_edge[KEY_SUB], kif.key_state, LAT);
    end
    $display("test_release_bounce: release at edge %0d", LAT);
  endtask

  task automatic test_simultaneous();
    clear_obs();
    drive(4'b0000);
    observe(20);
    for (int k = 0; k < NK; k++) begin
      n_checks++;
      if (press_edge[k] !== LAT || press_cnt[k] !== 1) begin
        n_fail++;
        $display("FAIL simul_press[%0d]: edge=%0d count=%0d, required edge=%0d count=1",
                 k, press_edge[k], press_cnt[k], LAT);
      end
    end
    clear_obs();
    drive(4'b1111);
    observe(20);
    n_checks++;
    if (both_hi !== 0 || rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] !== 4 || kif.key_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_release: both=%0d state=%b, required 0 and 0000", both_hi, kif.key_state);
    end
    $display("test_simultaneous: 4 presses, 4 releases");
  endtask

  task automatic test_reset_mid_filter();
    clear_obs();
    drive(4'b1011);
    // After 7 edges the channel sits in PRESS_FILT with cnt=4
    observe(7);
    @(negedge clk);
    reset = 1'b1;
    observe(3);
    n_checks++;
    if (press_cnt[KEY_SHL] !== 0 || kif.key_state !== 4'b0000 || kif.key_press !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_outputs: presses=%0d state=%b, required 0 and 0000",
               press_cnt[KEY_SHL], kif.key_state);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    observe(20);
    n_checks++;
    if (press_edge[KEY_SHL] !== LAT || press_cnt[KEY_SHL] !== 1) begin
      n_fail++;
      $display("FAIL midreset_press: edge=%0d count=%0d, required edge=%0d count=1",
               press_edge[KEY_SHL], press_cnt[KEY_SHL], LAT);
    end
    $display("test_reset_mid_filter: press at edge %0d", press_edge[KEY_SHL]);
  endtask

  task automatic test_long_hold();
    clear_obs();
    drive(4'b0011);
    observe(1000);
    n_checks++;
    if (press_cnt[KEY_SHR] !== 1 || rel_cnt[KEY_SHR] !== 0 || press_edge[KEY_SHR] !== LAT) begin
      n_fail++;
      $display("FAIL long_hold_pulses: presses=%0d releases=%0d edge=%0d, required 1 0 %0d",
               press_cnt[KEY_SHR], rel_cnt[KEY_SHR], press_edge[KEY_SHR], LAT);
    end
    n_checks++;
    if (state_hi[KEY_SHR] !== 1000 - LAT + 1) begin
      n_fail++;
      $display("FAIL long_hold_state: high cycles=%0d, required %0d",
               state_hi[KEY_SHR], 1000 - LAT + 1);
    end
    n_checks++;
    if (press_cnt[KEY_SHL] !== 0 || state_hi[KEY_SHL] !== 1000) begin
      n_fail++;
      $display("FAIL long_hold_other: shl presses=%0d high=%0d, required 0 and 1000",
               press_cnt[KEY_SHL], state_hi[KEY_SHL]);
    end
    $display("test_long_hold: 1 press over 1000 cycles");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    kif.key_in_n = 4'b1111;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_simultaneous();
    test_reset_mid_filter();
    test_long_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
